// File: rtl/keypad_scan_deb.sv
// keypad_scan_deb: column-scanning matrix keypad reader with whole-frame debounce and an event FIFO.
module keypad_scan_deb #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int SETTLE = 8,
    parameter int DEBOUNCE = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int N = ROWS * COLS,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_en,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [N-1:0]    keys,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IW-1:0]   evt_code,
    output logic            evt_press,
    output logic            evt_ovf,
    input  logic            ovf_clr
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMPARE, EMIT} state_t;
    state_t state, state_nxt;

    logic [SW-1:0] scnt;
    logic [CW-1:0] c;
    logic [IW-1:0] ei;
    logic [N-1:0]  frame, cand, diff;
    logic [MW-1:0] match, match_nxt;
    logic          s_last, c_last, e_last, accept;

    logic [IW:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr, rd;
    logic [NW-1:0] cnt, cnt_nxt;
    logic          push, pop, full, wr_en, head_push;
    logic [IW:0]   push_data;

    always_comb begin
        s_last = scnt == SW'(SETTLE - 1);
        c_last = c == CW'(COLS - 1);
        e_last = ei == IW'(N - 1);
        match_nxt = (frame != cand) ? MW'(1) : (match == MW'(DEBOUNCE)) ? match : match + MW'(1);
        accept = (match_nxt == MW'(DEBOUNCE)) && (frame != keys);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = scan_en ? SCAN : IDLE;
            SCAN:    state_nxt = (s_last && c_last) ? COMPARE : SCAN;
            COMPARE: state_nxt = accept ? EMIT : IDLE;
            EMIT:    state_nxt = e_last ? IDLE : EMIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        col = (state == SCAN) ? ~(COLS'(1) << c) : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt  <= '0;
            c     <= '0;
            ei    <= '0;
            frame <= '0;
            cand  <= '0;
            match <= '0;
            diff  <= '0;
            keys  <= '0;
        end else begin
            scnt <= (state == SCAN && !s_last) ? scnt + SW'(1) : '0;
            c    <= (state != SCAN) ? '0 : s_last ? c + CW'(1) : c;
            ei   <= (state == EMIT) ? ei + IW'(1) : '0;
            // Only the last settle cycle of each column lands in the frame.
            if (state == SCAN && s_last)
                frame <= (frame & ~(N'({ROWS{1'b1}}) << (c * ROWS))) | (N'(~row) << (c * ROWS));
            if (state == COMPARE) begin
                cand  <= frame;
                match <= match_nxt;
                if (accept) begin
                    diff <= frame ^ keys;
                    keys <= frame;
                end
            end
        end
    end

    always_comb begin
        push      = (state == EMIT) && diff[ei];
        pop       = evt_valid && evt_ready;
        full      = cnt == NW'(FIFO_DEPTH);
        wr_en     = push && (!full || pop);
        push_data = {ei, keys[ei]};
        cnt_nxt   = cnt + NW'(wr_en) - NW'(pop);
        head_push = cnt == NW'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr] <= push_data;
    end

    // Head is registered: take the incoming event when the queue drains to empty this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr        <= '0;
            rd        <= '0;
            cnt       <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_press <= 1'b0;
            evt_ovf   <= 1'b0;
        end else begin
            if (wr_en) wr <= wr + PW'(1);
            if (pop) rd <= rd + PW'(1);
            cnt                   <= cnt_nxt;
            evt_valid             <= cnt_nxt != '0;
            {evt_code, evt_press} <= head_push ? push_data : mem[rd + PW'(pop)];
            evt_ovf               <= (push && full && !pop) || (evt_ovf && !ovf_clr);
        end
    end
endmodule

// File: tb/tb_keypad_scan_deb.sv
// tb_keypad_scan_deb: keypad matrix model driving the scanner; debounce and event queue checked against a frame-history model.
module tb_keypad_scan_deb;
    localparam int ROWS = 4, COLS = 4, SETTLE = 8, DEB = 3, DEPTH = 4, N = 16;

    logic clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
    logic [3:0] row, col, evt_code;
    logic [15:0] keys, pressed = '0;
    logic evt_valid, evt_press, evt_ovf;

    always #5 clk = ~clk;

    keypad_scan_deb dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row(row), .col(col), .keys(keys),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
        .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
    );

    always_comb begin
        row = '1;
        for (int cc = 0; cc < COLS; cc++)
            for (int rr = 0; rr < ROWS; rr++)
                if (!col[cc] && pressed[cc*ROWS+rr]) row[rr] = 1'b0;
    end

    typedef struct packed {logic [3:0] code; logic press;} evt_t;
    typedef struct {logic [15:0] p; logic [15:0] k; int ev;} vec_t;

    logic [15:0] mkeys, hist[$];
    evt_t q[$];
    bit movf;
    int passed = 0, total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mkeys = '0;
        hist.delete();
        q.delete();
        movf = 0;
    endtask

    // A map is accepted once the last DEB frames are all identical and differ from the published map.
    task automatic model_frame(input logic [15:0] f);
        bit same;
        evt_t e;
        hist.push_back(f);
        if (hist.size() > DEB) hist.delete(0);
        same = 1;
        foreach (hist[i]) if (hist[i] != f) same = 0;
        if (hist.size() == DEB && same && f != mkeys) begin
            for (int i = 0; i < N; i++) begin
                if (f[i] != mkeys[i]) begin
                    e.code = 4'(i);
                    e.press = f[i];
                    if (q.size() < DEPTH) q.push_back(e);
                    else movf = 1;
                end
            end
            mkeys = f;
        end
    endtask

    task automatic start_frame();
        @(negedge clk) scan_en = 1'b1;
        @(posedge clk);
        @(negedge clk) scan_en = 1'b0;
    endtask

    task automatic do_frame(input logic [15:0] p);
        int bad;
        logic [3:0] e;
        pressed = p;
        start_frame();
        bad = 0;
        for (int k = 0; k < COLS * SETTLE; k++) begin
            e = ~(4'b0001 << (k / SETTLE));
            if (col !== e) bad++;
            @(negedge clk);
        end
        chk("col_scan_errors", bad, 0);
        chk("col_compare", col, 4'hF);
        @(negedge clk);
        model_frame(p);
        chk("keys", keys, mkeys);
        repeat (N + 2) @(negedge clk);
        chk("ovf", evt_ovf, movf);
        chk("valid", evt_valid, q.size() != 0);
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            chk("drain_valid", evt_valid, q.size() != 0);
            if (q.size() == 0) return;
            chk("evt_code", evt_code, q[0].code);
            chk("evt_press", evt_press, q[0].press);
            if (evt_valid) n++;
            evt_ready = 1'b1;
            @(posedge clk);
            #1 evt_ready = 1'b0;
            q.delete(0);
            @(negedge clk);
        end
    endtask

    task automatic clr_ovf();
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        movf = 0;
        chk("ovf_clr", evt_ovf, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[17];
        int n;
        logic [15:0] p;
        tbl = '{
            '{16'h0200, 16'h0000, 0}, '{16'h0200, 16'h0000, 0}, '{16'h0000, 16'h0000, 0},
            '{16'h0000, 16'h0000, 0}, '{16'h0000, 16'h0000, 0},
            '{16'h0200, 16'h0000, 0}, '{16'h0200, 16'h0000, 0}, '{16'h0200, 16'h0200, 1},
            '{16'h0000, 16'h0200, 0}, '{16'h0000, 16'h0200, 0}, '{16'h0000, 16'h0000, 1},
            '{16'h1008, 16'h0000, 0}, '{16'h1008, 16'h0000, 0}, '{16'h1008, 16'h1008, 2},
            '{16'h0000, 16'h1008, 0}, '{16'h0000, 16'h1008, 0}, '{16'h0000, 16'h0000, 2}
        };
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_col", col, 4'hF);
        chk("rst_keys", keys, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", evt_ovf, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_press", evt_press, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_frame(tbl[i].p);
            chk("tbl_keys", keys, tbl[i].k);
            drain(n);
            chk("tbl_events", n, tbl[i].ev);
        end

        for (int j = 0; j < 15; j++) do_frame(((j / 3) % 2 == 0) ? 16'h0020 : 16'h0000);
        chk("ovf_after_5", evt_ovf, 1);
        clr_ovf();
        drain(n);
        chk("fifo_kept", n, DEPTH);

        pressed = 16'h1008;
        start_frame();
        repeat (5) @(negedge clk);
        chk("pre_rst_col", col, 4'hE);
        rst_n = 1'b0;
        #1 chk("rst_scan_col", col, 4'hF);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        do_frame(16'h1008);
        do_frame(16'h1008);
        start_frame();
        repeat (47) @(negedge clk);
        chk("pre_rst_valid", evt_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_emit_col", col, 4'hF);
        chk("rst_emit_keys", keys, 0);
        chk("rst_emit_valid", evt_valid, 0);
        chk("rst_emit_ovf", evt_ovf, 0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        repeat (3) do_frame(16'h1008);
        chk("redetect_keys", keys, 16'h1008);
        drain(n);
        chk("redetect_events", n, 2);

        p = 16'h1008;
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 99) < 35) begin
                case ($urandom_range(0, 2))
                    0: p = '0;
                    1: p = 16'(1) << $urandom_range(0, 15);
                    default: p = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                endcase
            end
            do_frame(p);
            if ($urandom_range(0, 1) == 1) drain(n);
            if (movf) clr_ovf();
        end
        drain(n);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
